// File: rtl/if_fetch_queue.sv
// Prefetch queue between instruction fetch and decode: owns the fetch PC, buffers
// {pc, ir} pairs in a DEPTH-entry circular buffer and hands them to ID via valid/ready.
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     IM_AW    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [IM_AW-1:0]           im_addr,
    input  logic [XLEN-1:0]            im_data,
    input  logic                       fetch_en,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_ir,
    output logic [XLEN-1:0]            fetch_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                redirect_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] ir_mem_q [DEPTH];

    logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [15:0]     redirect_cnt_q, redirect_cnt_d;

    logic full, empty, push, pop;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    // Redirect suppresses both sides, so a head presented in that cycle is dropped.
    assign push  = fetch_en & (~full | pop) & ~redirect;
    assign pop   = ~empty & id_ready & ~redirect;

    always_comb begin
        rptr_d         = rptr_q;
        wptr_d         = wptr_q;
        count_d        = count_q;
        fetch_pc_d     = fetch_pc_q;
        redirect_cnt_d = redirect_cnt_q;
        if (redirect) begin
            rptr_d     = '0;
            wptr_d     = '0;
            count_d    = '0;
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (redirect_cnt_q != 16'hFFFF) begin
                redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
        end else begin
            if (push) begin
                wptr_d     = wptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q         <= '0;
            wptr_q         <= '0;
            count_q        <= '0;
            fetch_pc_q     <= RESET_PC;
            redirect_cnt_q <= '0;
        end else begin
            rptr_q         <= rptr_d;
            wptr_q         <= wptr_d;
            count_q        <= count_d;
            fetch_pc_q     <= fetch_pc_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q] <= fetch_pc_q;
            ir_mem_q[wptr_q] <= im_data;
        end
    end

    assign im_addr      = fetch_pc_q[IM_AW+1:2];
    assign id_valid     = ~empty;
    assign id_pc        = empty ? '0 : pc_mem_q[rptr_q];
    assign id_ir        = empty ? '0 : ir_mem_q[rptr_q];
    assign fetch_pc     = fetch_pc_q;
    assign count        = count_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: fill, full pop, drain, redirect, wrap-around, async reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  im_addr;
    logic [31:0] im_data;
    logic        fetch_en, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc, id_ir, fetch_pc;
    logic [2:0]  count;
    logic [15:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_head, exp_fetch;
    int          exp_cnt;
    logic        do_pop, do_push;

    if_fetch_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .im_addr      (im_addr),
        .im_data      (im_data),
        .fetch_en     (fetch_en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_ir        (id_ir),
        .fetch_pc     (fetch_pc),
        .count        (count),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    // Memory word k holds 0x1000 + k.
    assign im_data = 32'h1000 + {24'h0, im_addr};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        #12;
        check_eq("rst_valid", {31'h0, id_valid}, 32'h0);
        check_eq("rst_fetch_pc", fetch_pc, 32'h0);
        check_eq("rst_count", {29'h0, count}, 32'h0);
        check_eq("rst_ir", id_ir, 32'h0);
        check_eq("rst_rcnt", {16'h0, redirect_cnt}, 32'h0);

        // Fill with ID stalled.
        step();
        rst_n = 1'b1;
        step();
        check_eq("fill1_valid", {31'h0, id_valid}, 32'h1);
        check_eq("fill1_count", {29'h0, count}, 32'h1);
        check_eq("fill1_fetch_pc", fetch_pc, 32'h4);
        step();
        step();
        step();
        check_eq("fill4_count", {29'h0, count}, 32'h4);
        check_eq("fill4_fetch_pc", fetch_pc, 32'h10);
        check_eq("fill4_id_pc", id_pc, 32'h0);
        check_eq("fill4_id_ir", id_ir, 32'h1000);
        step();
        check_eq("full_hold_pc", fetch_pc, 32'h10);
        check_eq("full_hold_count", {29'h0, count}, 32'h4);

        // Single pop while full: push happens in the same cycle.
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check_eq("fullpop_count", {29'h0, count}, 32'h4);
        check_eq("fullpop_id_pc", id_pc, 32'h4);
        check_eq("fullpop_fetch_pc", fetch_pc, 32'h14);

        // Drain with fetch disabled; pc 0x10 must have been written.
        fetch_en = 1'b0;
        id_ready = 1'b1;
        step();
        check_eq("drain_pc8", id_pc, 32'h8);
        step();
        check_eq("drain_pcC", id_pc, 32'hC);
        step();
        check_eq("drain_pc10", id_pc, 32'h10);
        check_eq("drain_ir10", id_ir, 32'h1004);
        step();
        check_eq("drain_empty_valid", {31'h0, id_valid}, 32'h0);
        check_eq("drain_empty_pc", id_pc, 32'h0);
        check_eq("drain_fetch_hold", fetch_pc, 32'h14);

        // Async reset between edges, then refill 0x0..0xC.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst2_fetch_pc", fetch_pc, 32'h0);
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        id_ready = 1'b0;
        step();
        step();
        step();
        step();
        check_eq("refill_count", {29'h0, count}, 32'h4);

        // Redirect with ID ready: head pc 0 is discarded, target is word-aligned.
        redirect    = 1'b1;
        redirect_pc = 32'h46;
        id_ready    = 1'b1;
        step();
        redirect = 1'b0;
        check_eq("redir_count", {29'h0, count}, 32'h0);
        check_eq("redir_ir", id_ir, 32'h0);
        check_eq("redir_fetch_pc", fetch_pc, 32'h44);
        check_eq("redir_rcnt", {16'h0, redirect_cnt}, 32'h1);
        step();
        check_eq("redir_next_pc", id_pc, 32'h44);
        check_eq("redir_next_ir", id_ir, 32'h1011);
        check_eq("redir_next_count", {29'h0, count}, 32'h1);

        // Wrap-around with random id_ready, checked against a small occupancy model.
        exp_head  = 32'h44;
        exp_fetch = 32'h48;
        exp_cnt   = 1;
        for (int i = 0; i < 12; i++) begin
            id_ready = 1'($urandom_range(0, 1));
            do_pop   = (exp_cnt > 0) && id_ready;
            do_push  = fetch_en && ((exp_cnt < 4) || do_pop);
            step();
            if (do_pop) exp_head = exp_head + 32'h4;
            if (do_push) exp_fetch = exp_fetch + 32'h4;
            exp_cnt = exp_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            check_eq("wrap_count", {29'h0, count}, 32'(exp_cnt));
            check_eq("wrap_fetch_pc", fetch_pc, exp_fetch);
            if (exp_cnt > 0) begin
                check_eq("wrap_id_pc", id_pc, exp_head);
                check_eq("wrap_id_ir", id_ir, 32'h1000 + (exp_head >> 2));
            end
        end

        // Redirect while fetch is disabled still clears and retargets.
        fetch_en    = 1'b0;
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h3;
        step();
        redirect = 1'b0;
        check_eq("redir2_count", {29'h0, count}, 32'h0);
        check_eq("redir2_fetch_pc", fetch_pc, 32'h0);
        check_eq("redir2_rcnt", {16'h0, redirect_cnt}, 32'h2);
        fetch_en = 1'b1;
        step();
        step();
        step();
        check_eq("pre_async_count", {29'h0, count}, 32'h3);
        check_eq("pre_async_fetch_pc", fetch_pc, 32'hC);

        // Async reset mid-run takes effect before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {31'h0, id_valid}, 32'h0);
        check_eq("async_fetch_pc", fetch_pc, 32'h0);
        check_eq("async_rcnt", {16'h0, redirect_cnt}, 32'h0);
        check_eq("async_count", {29'h0, count}, 32'h0);
        check_eq("async_id_pc", id_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
